dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Data-memory responder for the pipelined ARM core. It is the slave end of the core's Memory-stage load/store request interface.
- Accepts one request at a time and inserts LATENCY wait cycles.
- Returns read data or commits write data.
- Drives stall_m so the pipeline holds its M/W stages until the response arrives.
- Replaces the zero-latency ideal data memory, so the core can be verified against realistic memory timing.

Parameters:
- ADDR_BITS, 6, word-address width; memory depth = 2^ADDR_BITS 32-bit words.
- LATENCY, 2, wait cycles between accept and response (0..15).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  M-stage request present; held stable until rsp_valid
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address (ALUResultM)
- req_wdata  in  32  store data (WriteDataM)
- req_ready  out  1  responder can accept this cycle
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  load data, valid with rsp_valid
- rsp_err  out  1  misaligned access, valid with rsp_valid
- stall_m  out  1  pipeline hold request

Behaviour:
- Interface decision: one clock, clk. Reset is asynchronous and active-low, port name reset.
- Reset (reset=0, any time, including mid-transaction):
  - state = IDLE, wait counter = 0, latched request cleared.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, stall_m=0.
  - Memory array is not cleared.
  - An in-flight store that has not reached its RESP edge is discarded.
- States:
  - IDLE:
    - req_ready=1.
    - On an edge with req_valid=1: latch we/addr/wdata.
    - If LATENCY=0, go to RESP.
    - Otherwise load cnt=LATENCY and go to WAIT.
  - WAIT:
    - req_ready=0, cnt decrements each edge.
    - On the edge where cnt==1, go to RESP.
  - RESP:
    - rsp_valid=1 for exactly one cycle, then IDLE on the next edge.
    - Loads: rsp_rdata = mem[idx] (combinational from the latched index).
    - Stores: mem[idx] <= wdata on the edge leaving RESP; rsp_rdata = 0.
- Latency: counting the accepting edge as edge 1, rsp_valid is high in the cycle following edge LATENCY+1.
- Back-to-back requests: there is one mandatory IDLE cycle after RESP. A request held through RESP is not re-accepted as a duplicate, because the core drops or changes the request when it sees rsp_valid.
- stall_m = req_valid & ~rsp_valid, combinational.
  - stall_m is 0 when req_valid=0.
  - stall_m deasserts in the RESP cycle so the pipeline advances on that edge.
- Indexing:
  - idx = addr[ADDR_BITS+1:2].
  - Upper address bits are ignored, so addresses wrap modulo 2^(ADDR_BITS+2).
- Misaligned access (addr[1:0] != 0):
  - Still takes the full latency.
  - In RESP: rsp_err=1, rsp_rdata=0, and a store is suppressed (memory unchanged).
- Latching:
  - Request fields are sampled only at the accepting edge.
  - Changes to req_* during WAIT or RESP are ignored.
  - req_valid dropping during WAIT does not abort: the response still issues and a store still commits.
- Load of a never-written word returns X in simulation. The bench must preload or write the word first.

Test Plan:
1. Reset, then LATENCY=2: store addr 0x10 data 0xDEADBEEF.
   - Expect: stall_m=1 for 2 cycles after the accept cycle, rsp_valid one cycle after that, rsp_err=0.
   - Then a load from 0x10 returns 0xDEADBEEF with rsp_valid after 3 edges.
2. Boundary wrap with ADDR_BITS=6.
   - Store 0x00000111 to 0xFC, then load 0x1FC.
   - Expect: rsp_rdata=0x00000111 (aliasing).
3. Misaligned store to 0x22 with data 0x5555AAAA.
   - Expect: rsp_err=1, rsp_rdata=0.
   - A subsequent load from 0x20 returns the prior value unchanged.
4. LATENCY=0: load presented in IDLE.
   - Expect: rsp_valid in the cycle after the accepting edge, stall_m=1 only in the accept cycle.
   - Back-to-back request: req_ready=0 in RESP and an IDLE gap before the second accept.
5. Reset asserted (reset=0) during WAIT of a store to 0x30 with 0x12345678.
   - Expect: immediate async return to IDLE with all outputs 0 and req_ready=1.
   - After reset release, a load from 0x30 returns the old contents, not 0x12345678.
6. req_addr/req_wdata changed during WAIT.
   - Expect: the response and the committed store use the originally latched values.

Source files
------------

// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
//   Memory-stage load/store request/response bundle between the pipelined
//   core (master) and a data-memory responder (slave).
//
//   req_valid  master->slave  request present, held stable until rsp_valid
//   req_we     master->slave  1 = store, 0 = load
//   req_addr   master->slave  32-bit byte address
//   req_wdata  master->slave  32-bit store data
//   req_ready  slave->master  responder can accept a request this cycle
//   rsp_valid  slave->master  one-cycle response strobe
//   rsp_rdata  slave->master  load data, qualified by rsp_valid
//   rsp_err    slave->master  misaligned access, qualified by rsp_valid
//   stall_m    slave->master  hold M/W pipeline stages
// ---------------------------------------------------------------------------
interface dmem_responder_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall_m;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall_m
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall_m
    );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the pipelined core's Memory stage. Accepts one
//   load/store at a time, waits LATENCY cycles, then issues a one-cycle
//   response. Stores commit on the edge leaving the response cycle.
//   Misaligned accesses (addr[1:0] != 0) take the full latency, report
//   rsp_err and never modify memory.
//
//   Parameters:
//     ADDR_BITS  word-address width, depth = 2**ADDR_BITS words (<= 29)
//     LATENCY    wait cycles between accept and response (0..15)
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset (memory contents preserved)
//     bus    dmem_responder_if slave modport (request/response/stall)
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_BITS = 6,
    parameter int LATENCY   = 2
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] LAT = 4'(LATENCY);
    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        we_q,    we_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic [31:0] mem_q [DEPTH];

    logic [ADDR_BITS-1:0] idx;
    logic                 misaligned;
    logic                 in_resp;
    logic                 mem_we;

    // Upper address bits are deliberately dropped so addresses alias
    // modulo 2**(ADDR_BITS+2).
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_q[31:ADDR_BITS+2];

    assign idx        = addr_q[ADDR_BITS+1:2];
    assign misaligned = |addr_q[1:0];
    assign in_resp    = (state_q == S_RESP);

    // Next-state logic; request fields are captured only on the accept edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (LAT == 4'd0) begin
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = LAT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Memory is never cleared. The write is qualified with reset so a store
    // caught by reset at its commit edge is discarded.
    assign mem_we = in_resp & we_q & ~misaligned & reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= wdata_q;
        end
    end

    always_comb begin
        bus.req_ready = (state_q == S_IDLE);
        bus.rsp_valid = in_resp;
        bus.rsp_err   = in_resp & misaligned;
        bus.rsp_rdata = '0;
        if (in_resp && !we_q && !misaligned) begin
            bus.rsp_rdata = mem_q[idx];
        end
        // Releases the pipeline in the response cycle so it advances on
        // the same edge that retires the request.
        bus.stall_m   = bus.req_valid & ~in_resp;
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    dmem_responder_if if2 ();
    dmem_responder_if if0 ();

    dmem_responder #(.ADDR_BITS(6), .LATENCY(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2.slave)
    );

    dmem_responder #(.ADDR_BITS(6), .LATENCY(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [64];
    int          compared   = 0;
    int          mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.tag   = tag;
        e.rdata = rdata;
        e.err   = err;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] rdata, input logic err);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({e.tag, "_rdata"}, rdata, e.rdata);
            chk({e.tag, "_err"}, {31'd0, err}, {31'd0, e.err});
        end
    endtask

    // One complete transaction on the LATENCY=2 responder. With corrupt set,
    // the request address/data are altered right after the accept edge.
    task automatic req2(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit corrupt);
        logic        mis;
        logic [5:0]  widx;
        logic [31:0] er;
        bit          got;
        int          edges;
        mis  = (addr[1:0] != 2'b00);
        widx = addr[7:2];
        er   = (we || mis) ? 32'd0 : model[widx];
        if (we && !mis) model[widx] = wdata;
        push_exp(tag, er, mis);

        @(negedge clk);
        if2.req_valid = 1'b1;
        if2.req_we    = we;
        if2.req_addr  = addr;
        if2.req_wdata = wdata;
        #1;
        chk({tag, "_ready_pre"}, {31'd0, if2.req_ready}, 32'd1);
        chk({tag, "_stall_pre"}, {31'd0, if2.stall_m}, 32'd1);

        got   = 1'b0;
        edges = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            edges = e;
            if (if2.rsp_valid) begin
                got = 1'b1;
                break;
            end
            chk({tag, "_stall_wait"}, {31'd0, if2.stall_m}, 32'd1);
            chk({tag, "_ready_wait"}, {31'd0, if2.req_ready}, 32'd0);
            if (corrupt && e == 1) begin
                if2.req_addr  = addr ^ 32'h0000_000C;
                if2.req_wdata = ~wdata;
            end
        end
        chk({tag, "_rsp_seen"}, {31'd0, got}, 32'd1);
        if (got) begin
            chk({tag, "_latency"}, 32'(edges), 32'd3);
            chk({tag, "_stall_rsp"}, {31'd0, if2.stall_m}, 32'd0);
            chk({tag, "_ready_rsp"}, {31'd0, if2.req_ready}, 32'd0);
            pop_check(if2.rsp_rdata, if2.rsp_err);
        end
        if2.req_valid = 1'b0;
        if2.req_we    = 1'b0;
        if2.req_addr  = '0;
        if2.req_wdata = '0;
        @(posedge clk);
        #1;
        chk({tag, "_rsp_once"}, {31'd0, if2.rsp_valid}, 32'd0);
        chk({tag, "_ready_idle"}, {31'd0, if2.req_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        if2.req_valid = 1'b0; if2.req_we = 1'b0; if2.req_addr = '0; if2.req_wdata = '0;
        if0.req_valid = 1'b0; if0.req_we = 1'b0; if0.req_addr = '0; if0.req_wdata = '0;

        // Reset state
        #12;
        chk("rst_ready2", {31'd0, if2.req_ready}, 32'd1);
        chk("rst_valid2", {31'd0, if2.rsp_valid}, 32'd0);
        chk("rst_rdata2", if2.rsp_rdata, 32'd0);
        chk("rst_err2",   {31'd0, if2.rsp_err}, 32'd0);
        chk("rst_stall2", {31'd0, if2.stall_m}, 32'd0);
        chk("rst_ready0", {31'd0, if0.req_ready}, 32'd1);
        chk("rst_valid0", {31'd0, if0.rsp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Store then load
        req2("st10", 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        req2("ld10", 1'b0, 32'h10, 32'h0, 1'b0);

        // Address aliasing at the top of the 64-word array
        req2("stFC",  1'b1, 32'hFC,  32'h0000_0111, 1'b0);
        req2("ld1FC", 1'b0, 32'h1FC, 32'h0, 1'b0);

        // Misaligned store is suppressed
        req2("st20",  1'b1, 32'h20, 32'h0BAD_0020, 1'b0);
        req2("st22m", 1'b1, 32'h22, 32'h5555_AAAA, 1'b0);
        req2("ld22m", 1'b0, 32'h22, 32'h0, 1'b0);
        req2("ld20",  1'b0, 32'h20, 32'h0, 1'b0);

        // Request fields changed during WAIT are ignored
        req2("st44",  1'b1, 32'h44, 32'h4444_4444, 1'b0);
        req2("st48c", 1'b1, 32'h48, 32'h1111_2222, 1'b1);
        req2("ld48c", 1'b0, 32'h48, 32'h0, 1'b1);
        req2("ld44",  1'b0, 32'h44, 32'h0, 1'b0);

        // Reset during WAIT discards the in-flight store
        req2("st30", 1'b1, 32'h30, 32'hA5A5_0030, 1'b0);
        @(negedge clk);
        if2.req_valid = 1'b1;
        if2.req_we    = 1'b1;
        if2.req_addr  = 32'h30;
        if2.req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        chk("rstw_inwait", {31'd0, if2.req_ready}, 32'd0);
        #2;
        reset         = 1'b0;
        if2.req_valid = 1'b0;
        #1;
        chk("rstw_ready", {31'd0, if2.req_ready}, 32'd1);
        chk("rstw_valid", {31'd0, if2.rsp_valid}, 32'd0);
        chk("rstw_rdata", if2.rsp_rdata, 32'd0);
        chk("rstw_err",   {31'd0, if2.rsp_err}, 32'd0);
        chk("rstw_stall", {31'd0, if2.stall_m}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rstw_norsp", {31'd0, if2.rsp_valid}, 32'd0);
        req2("ld30", 1'b0, 32'h30, 32'h0, 1'b0);

        // LATENCY=0 responder, back-to-back requests
        @(negedge clk);
        if0.req_valid = 1'b1;
        if0.req_we    = 1'b1;
        if0.req_addr  = 32'h40;
        if0.req_wdata = 32'hCAFE_0040;
        push_exp("l0st40", 32'd0, 1'b0);
        #1;
        chk("l0_ready_pre", {31'd0, if0.req_ready}, 32'd1);
        chk("l0_stall_pre", {31'd0, if0.stall_m}, 32'd1);
        @(posedge clk);
        #1;
        chk("l0_rsp1",       {31'd0, if0.rsp_valid}, 32'd1);
        chk("l0_stall_rsp1", {31'd0, if0.stall_m}, 32'd0);
        chk("l0_ready_rsp1", {31'd0, if0.req_ready}, 32'd0);
        pop_check(if0.rsp_rdata, if0.rsp_err);
        if0.req_we    = 1'b0;
        if0.req_wdata = '0;
        push_exp("l0ld40", 32'hCAFE_0040, 1'b0);
        @(posedge clk);
        #1;
        chk("l0_gap_rsp",   {31'd0, if0.rsp_valid}, 32'd0);
        chk("l0_gap_ready", {31'd0, if0.req_ready}, 32'd1);
        chk("l0_gap_stall", {31'd0, if0.stall_m}, 32'd1);
        @(posedge clk);
        #1;
        chk("l0_rsp2",       {31'd0, if0.rsp_valid}, 32'd1);
        chk("l0_stall_rsp2", {31'd0, if0.stall_m}, 32'd0);
        pop_check(if0.rsp_rdata, if0.rsp_err);
        if0.req_valid = 1'b0;
        if0.req_addr  = '0;
        @(posedge clk);
        #1;
        chk("l0_end_rsp",   {31'd0, if0.rsp_valid}, 32'd0);
        chk("l0_end_ready", {31'd0, if0.req_ready}, 32'd1);
        chk("l0_end_stall", {31'd0, if0.stall_m}, 32'd0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
